// File: rtl/cic_decimator_if.sv
// Sample-stream bundle for the CIC decimator: input samples and rate request in,
// decimated samples out. The master side drives the inputs and the slave side is the decimator.
interface cic_decimator_if #(
    parameter int IN_WIDTH      = 1,
    parameter int OUT_WIDTH     = 8,
    parameter int MAX_RATE_LOG2 = 4
) ();
    localparam int RATE_W = $clog2(MAX_RATE_LOG2 + 1);

    logic                 in_valid;
    logic [IN_WIDTH-1:0]  in_data;
    logic [RATE_W-1:0]    rate_log2;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;

    // Producer of samples and consumer of decimated output.
    modport master (
        output in_valid,
        output in_data,
        output rate_log2,
        input  out_valid,
        input  out_data
    );

    // The decimator itself.
    modport slave (
        input  in_valid,
        input  in_data,
        input  rate_log2,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/cic_decimator.sv
// Runtime-selectable power-of-two CIC decimator (Hogenauer, differential delay 1).
// STAGES integrators run at the input rate, STAGES combs run once per R accepted
// samples, and the comb result is rescaled so that full-scale input maps to
// full-scale OUT_WIDTH output for every supported ratio R = 2^k.
module cic_decimator #(
    parameter int STAGES        = 3,
    parameter int MAX_RATE_LOG2 = 4,
    parameter int IN_WIDTH      = 1,
    parameter int OUT_WIDTH     = 8
) (
    input  logic           clk,
    input  logic           rst,
    cic_decimator_if.slave bus
);
    // Datapath width sized for the largest ratio; wrap-around inside the chain is harmless
    // because the final result always fits in W bits.
    localparam int W   = IN_WIDTH + STAGES * MAX_RATE_LOG2;
    localparam int KW  = $clog2(MAX_RATE_LOG2 + 1);
    localparam int CW  = MAX_RATE_LOG2;
    localparam int SW  = W + OUT_WIDTH;
    localparam int WKW = $clog2(SW + 1);
    localparam int WUW = $clog2(STAGES + 1);

    // ---------------------------------------------------------------------
    // Rate control
    // ---------------------------------------------------------------------
    logic [KW-1:0]  k_clamped;
    logic [KW-1:0]  k_reg;
    logic           flush;
    logic           accept;
    logic [CW-1:0]  cnt_reg;
    logic [CW-1:0]  cnt_last_value;
    logic           cnt_last;
    logic           dec_event;
    logic [WUW-1:0] warm_reg;
    logic           warm_done;

    // Clamp the requested exponent into the supported range 1..MAX_RATE_LOG2.
    always_comb begin
        k_clamped = bus.rate_log2;
        if (bus.rate_log2 == '0) begin
            k_clamped = KW'(1);
        end else if (bus.rate_log2 > KW'(MAX_RATE_LOG2)) begin
            k_clamped = KW'(MAX_RATE_LOG2);
        end
    end

    // Any change of the effective ratio restarts the filter from a clean state.
    assign flush  = (k_clamped != k_reg);
    assign accept = bus.in_valid && !flush;

    // R-1 computed modulo 2^CW: at k = MAX_RATE_LOG2 the shift wraps to zero and
    // the subtraction yields all ones, which is exactly R-1.
    assign cnt_last_value = (CW'(1) << k_reg) - CW'(1);
    assign cnt_last       = (cnt_reg == cnt_last_value);
    assign dec_event      = accept && cnt_last;
    assign warm_done      = (warm_reg == WUW'(STAGES));

    // Ratio register, phase counter within the decimation frame and warm-up counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_reg    <= k_clamped;
            cnt_reg  <= '0;
            warm_reg <= '0;
        end else if (flush) begin
            k_reg    <= k_clamped;
            cnt_reg  <= '0;
            warm_reg <= '0;
        end else if (accept) begin
            cnt_reg <= cnt_last ? '0 : cnt_reg + CW'(1);
            if (dec_event && !warm_done) begin
                warm_reg <= warm_reg + WUW'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Integrator chain (input rate)
    // ---------------------------------------------------------------------
    logic [W-1:0] integ_reg  [STAGES];
    logic [W-1:0] integ_next [STAGES];

    // Each stage sums its own state with the freshly updated output of the previous
    // stage, so the whole chain settles within the accepting cycle.
    assign integ_next[0] = integ_reg[0] + W'(bus.in_data);
    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_integ
            assign integ_next[gi] = integ_reg[gi] + integ_next[gi-1];
        end
    endgenerate

    // Integrators advance only on accepted samples; gaps in in_valid leave them frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                integ_reg[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                integ_reg[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < STAGES; i++) begin
                integ_reg[i] <= integ_next[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Comb chain (output rate)
    // ---------------------------------------------------------------------
    logic [W-1:0] comb_in      [STAGES];
    logic [W-1:0] comb_out     [STAGES];
    logic [W-1:0] comb_dly_reg [STAGES];
    logic [W-1:0] comb_result;

    // The comb chain sees the last integrator including the current sample.
    assign comb_in[0] = integ_next[STAGES-1];
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_comb
            assign comb_out[gi] = comb_in[gi] - comb_dly_reg[gi];
            if (gi > 0) begin : g_link
                assign comb_in[gi] = comb_out[gi-1];
            end
        end
    endgenerate
    assign comb_result = comb_out[STAGES-1];

    // Comb delay elements capture their inputs only on decimation events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                comb_dly_reg[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                comb_dly_reg[i] <= '0;
            end
        end else if (dec_event) begin
            for (int i = 0; i < STAGES; i++) begin
                comb_dly_reg[i] <= comb_in[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output scaling
    // ---------------------------------------------------------------------
    logic [WKW-1:0]       wk;
    logic [SW-1:0]        masked;
    logic [SW-1:0]        shifted;
    logic [OUT_WIDTH-1:0] scaled;

    // The meaningful bits of the comb result span Wk = IN_WIDTH + STAGES*k; align
    // that field's MSB with the output MSB, truncating or zero-padding below it.
    always_comb begin
        wk      = WKW'(IN_WIDTH) + WKW'(STAGES) * WKW'(k_reg);
        masked  = SW'(comb_result) & ((SW'(1) << wk) - SW'(1));
        shifted = masked;
        if (wk >= WKW'(OUT_WIDTH)) begin
            shifted = masked >> (wk - WKW'(OUT_WIDTH));
        end else begin
            shifted = masked << (WKW'(OUT_WIDTH) - wk);
        end
        scaled = shifted[OUT_WIDTH-1:0];
    end

    logic                 out_valid_reg;
    logic [OUT_WIDTH-1:0] out_data_reg;

    // Registered output: strobe one cycle after each post-warm-up decimation event,
    // data held between strobes and across flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (dec_event && warm_done) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= scaled;
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;

endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 The block SHALL expose parameter STAGES, default 3, meaning the number of integrator and comb stages (1..6).
REQ-002 The block SHALL expose parameter MAX_RATE_LOG2, default 4, meaning the largest supported decimation exponent; the decimation ratio R = 2^k.
REQ-003 The block SHALL expose parameter IN_WIDTH, default 1, meaning the unsigned input sample width; 1 = PDM bitstream.
REQ-004 The block SHALL expose parameter OUT_WIDTH, default 8, meaning the unsigned output sample width.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  1  in_data is accepted on a rising clk edge while high.
REQ-009 in_data  input  IN_WIDTH  unsigned input sample.
REQ-010 rate_log2  input  clog2(MAX_RATE_LOG2+1)  requested decimation exponent k.
REQ-011 out_valid  output  1  one-cycle strobe marking a new out_data.
REQ-012 out_data  output  OUT_WIDTH  decimated, scaled, unsigned sample; held between strobes.

Function
REQ-013 Internal datapath width SHALL be W = IN_WIDTH + STAGES*MAX_RATE_LOG2.
- All integrator and comb arithmetic is modulo 2^W, with intentional wrap-around.
- No saturation inside the chain.
REQ-014 The effective exponent k SHALL be rate_log2 clamped to 1..MAX_RATE_LOG2: 0 maps to 1; values above MAX_RATE_LOG2 map to MAX_RATE_LOG2.
REQ-015 The integrators SHALL update only on accepted samples.
- Stage 0 adds zero-extended in_data.
- Stage i adds the updated output of stage i-1 in the same cycle.
REQ-016 A sample counter SHALL count accepted samples 0..R-1 and wrap to 0.
- Decimation event: an accepted sample while the counter equals R-1.
- in_valid gaps SHALL NOT change results.
REQ-017 On a decimation event, the comb chain SHALL process the last integrator's updated value (including the current sample).
- Each comb stage outputs input minus its stored previous input, then stores the new input.
- Comb registers change only on decimation events.
REQ-018 Scaling SHALL use Wk = IN_WIDTH + STAGES*k, and out_data = (comb result mod 2^Wk), with truncation (floor):
- shifted right by Wk-OUT_WIDTH when Wk >= OUT_WIDTH;
- shifted left by OUT_WIDTH-Wk otherwise.
REQ-019 out_data and out_valid SHALL be registered, so out_valid pulses exactly one cycle after the clock edge of the decimation event.
REQ-020 A warm-up counter SHALL suppress out_valid, and leave out_data unchanged, for the first STAGES decimation events after reset or flush.
REQ-021 The block SHALL hold an internal registered copy of k.
- When clamped rate_log2 differs from it on any clock edge, that edge SHALL load the new k and flush.
- Flush clears integrators, combs, sample and warm-up counters, and out_valid; out_data is unchanged.
- Flush discards any in_data presented that cycle.
REQ-022 If in_valid is high on a flush edge, the flush SHALL take priority.
REQ-023 With constant in_data, each emitted output after warm-up SHALL equal in_data*R^STAGES scaled per REQ-018.

Reset
REQ-024 While rst is high, all integrators, combs, counters, out_valid and out_data SHALL be 0 immediately (asynchronous reset), and the stored k SHALL load the clamped rate_log2.
REQ-025 After rst is released, processing SHALL start on the first rising clk edge with warm-up active.
REQ-026 Assertion of rst mid-operation SHALL abort any pending output; no out_valid follows from pre-reset samples.

Verification
REQ-027 The bench SHALL cover these directed scenarios (defaults, k=2, R=4; IN_WIDTH=1, STAGES=3, OUT_WIDTH=8):
- Constant-one input: in_data=1 and in_valid=1 every cycle -> first out_valid after 16 accepted samples, out_data=0x80, then every 4 cycles 0x80.
- Zero input: in_data=0 -> every out_data=0x00, and out_valid every 4 cycles after warm-up.
- Gappy input: in_valid toggling 1,0 with constant ones -> same 0x80 values, with out_valid every 8 cycles.
- Rate change: switch k 2->3 mid-stream -> no out_valid until 32 accepted samples after the change edge, then 0x80 every 8 samples.
- Reset: pulse rst asynchronously mid-frame -> out_data=0x00 and out_valid=0 immediately, then the first valid output again after 16 samples.
- Wrap-around: constant ones for more than 2^W samples (W=13) -> out_data stays 0x80 throughout.
